// File: rtl/lr_car_queue_sensor_pkg.sv
// Shared light codes and debounce state encoding for the local-road sensor.
package lr_car_queue_sensor_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        StLow,
        StRiseChk,
        StHigh,
        StFallChk
    } db_state_e;

    function automatic logic light_legal(input logic [2:0] light);
        return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW) || (light == LIGHT_RED);
    endfunction

endpackage

// File: rtl/lr_car_queue_sensor_if.sv
// Sensor-side signal bundle: loop detector and light in, queue status out.
interface lr_car_queue_sensor_if #(
    parameter int unsigned CNT_W = 4
);
    logic             car_arrive_raw;
    logic [2:0]       lr_light;
    logic             lr_has_car;
    logic [CNT_W-1:0] car_count;
    logic             car_departed;
    logic             overflow;
    logic             light_err;

    modport master (
        input  car_arrive_raw,
        input  lr_light,
        output lr_has_car,
        output car_count,
        output car_departed,
        output overflow,
        output light_err
    );

    modport slave (
        output car_arrive_raw,
        output lr_light,
        input  lr_has_car,
        input  car_count,
        input  car_departed,
        input  overflow,
        input  light_err
    );
endinterface

// File: rtl/lr_car_queue_sensor_sync_debounce.sv
// Two-FF synchronizer plus level debounce; pulses rise on the edge a high level is accepted.
module lr_car_queue_sensor_sync_debounce
    import lr_car_queue_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

    logic      sync1_q, sync_q;
    db_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= StLow;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds the number of stable samples already seen at the candidate level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise    = 1'b0;
        unique case (state_q)
            StLow: begin
                if (sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StHigh;
                        cnt_d   = 4'd0;
                        rise    = 1'b1;
                    end else begin
                        state_d = StRiseChk;
                        cnt_d   = 4'd1;
                    end
                end
            end
            StRiseChk: begin
                if (!sync_q) begin
                    state_d = StLow;
                    cnt_d   = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StHigh;
                    cnt_d   = 4'd0;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHigh: begin
                if (!sync_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StLow;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = StFallChk;
                        cnt_d   = 4'd1;
                    end
                end
            end
            StFallChk: begin
                if (sync_q) begin
                    state_d = StHigh;
                    cnt_d   = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = StLow;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/lr_car_queue_sensor.sv
// Local-road car queue: counts debounced arrivals, retires cars on sustained green.
module lr_car_queue_sensor
    import lr_car_queue_sensor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DEPART_CYCLES   = 5,
    parameter int unsigned MAX_CARS        = 15,
    parameter int unsigned CNT_W           = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lr_car_queue_sensor_if.master bus
);

    localparam logic [CNT_W-1:0] COUNT_MAX  = CNT_W'(MAX_CARS);
    localparam logic [3:0]       TIMER_LAST = 4'(DEPART_CYCLES - 1);

    logic             arrive;
    logic             green, depart;
    logic [3:0]       timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             departed_q;
    logic             overflow_q, overflow_d;
    logic             light_err_q, light_err_d;

    lr_car_queue_sensor_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (bus.car_arrive_raw),
        .rise (arrive)
    );

    // Only the exact green code counts, so an illegal light never advances the timer.
    always_comb begin
        green   = (bus.lr_light == LIGHT_GREEN);
        depart  = 1'b0;
        timer_d = 4'd0;
        if (green && (count_q != '0)) begin
            if (timer_q == TIMER_LAST) begin
                depart = 1'b1;
            end else begin
                timer_d = timer_q + 4'd1;
            end
        end

        count_d    = count_q;
        overflow_d = overflow_q;
        if (arrive && !depart) begin
            if (count_q == COUNT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (depart && !arrive) begin
            count_d = count_q - CNT_W'(1);
        end

        light_err_d = light_err_q | ~light_legal(bus.lr_light);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q     <= 4'd0;
            count_q     <= '0;
            departed_q  <= 1'b0;
            overflow_q  <= 1'b0;
            light_err_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            count_q     <= count_d;
            departed_q  <= depart;
            overflow_q  <= overflow_d;
            light_err_q <= light_err_d;
        end
    end

    assign bus.lr_has_car   = (count_q != '0);
    assign bus.car_count    = count_q;
    assign bus.car_departed = departed_q;
    assign bus.overflow     = overflow_q;
    assign bus.light_err    = light_err_q;

endmodule

// File: tb/tb_lr_car_queue_sensor.sv
// Directed and randomized bench for lr_car_queue_sensor against a cycle-level queue model.
module tb_lr_car_queue_sensor;
    import lr_car_queue_sensor_pkg::*;

    localparam int DEB = 4;
    localparam int DEP = 5;
    localparam int MAXC = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass = 0;

    lr_car_queue_sensor_if #(.CNT_W(4)) bus ();

    lr_car_queue_sensor #(
        .DEBOUNCE_CYCLES(DEB),
        .DEPART_CYCLES  (DEP),
        .MAX_CARS       (MAXC),
        .CNT_W          (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_count;
    bit m_ov, m_lerr, m_dep;
    bit m_level;     // accepted debounced level
    int m_run;       // consecutive synchronized samples disagreeing with m_level
    int m_green;     // green edges with cars waiting since last departure
    bit raw_hist[$]; // raw value seen at each edge since reset

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit rst, input bit raw, input logic [2:0] light);
        bit s;
        bit arrive;
        bit dep;
        if (!rst) begin
            m_count = 0; m_ov = 0; m_lerr = 0; m_dep = 0;
            m_level = 0; m_run = 0; m_green = 0;
            raw_hist.delete();
            return;
        end
        // The synchronizer delays raw by two edges
        s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
        raw_hist.push_back(raw);
        if (raw_hist.size() > 4) void'(raw_hist.pop_front());

        arrive = 0;
        if (s != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                m_level = s;
                m_run = 0;
                arrive = s;
            end
        end else begin
            m_run = 0;
        end

        dep = 0;
        if (light == LIGHT_GREEN && m_count > 0) begin
            m_green++;
            if (m_green == DEP) begin
                dep = 1;
                m_green = 0;
            end
        end else begin
            m_green = 0;
        end

        if (light != LIGHT_GREEN && light != LIGHT_YELLOW && light != LIGHT_RED) m_lerr = 1;

        if (arrive && !dep) begin
            if (m_count == MAXC) m_ov = 1;
            else m_count++;
        end else if (dep && !arrive) begin
            m_count--;
        end
        m_dep = dep;
    endtask

    task automatic tick(input bit rst, input bit raw, input logic [2:0] light);
        rst_n = rst;
        bus.car_arrive_raw = raw;
        bus.lr_light = light;
        @(posedge clk);
        model_step(rst, raw, light);
        #1;
        check("car_count", int'(bus.car_count), m_count);
        check("lr_has_car", int'(bus.lr_has_car), int'(m_count != 0));
        check("car_departed", int'(bus.car_departed), int'(m_dep));
        check("overflow", int'(bus.overflow), int'(m_ov));
        check("light_err", int'(bus.light_err), int'(m_lerr));
    endtask

    task automatic do_reset();
        tick(0, 0, LIGHT_RED);
        tick(0, 0, LIGHT_RED);
    endtask

    task automatic hold(input bit raw, input logic [2:0] light, input int n);
        for (int i = 0; i < n; i++) tick(1, raw, light);
    endtask

    task automatic add_cars(input int n);
        for (int i = 0; i < n; i++) begin
            hold(1, LIGHT_RED, 7);
            hold(0, LIGHT_RED, 7);
        end
    endtask

    initial begin
        logic [2:0] light;
        int r;
        bit raw;
        int len;

        rst_n = 0;
        bus.car_arrive_raw = 0;
        bus.lr_light = LIGHT_RED;

        // 1: single held arrival
        do_reset();
        hold(1, LIGHT_RED, 5);
        check("t1_before_edge6", int'(bus.car_count), 0);
        hold(1, LIGHT_RED, 1);
        check("t1_edge6", int'(bus.car_count), 1);
        hold(1, LIGHT_RED, 4);
        hold(0, LIGHT_RED, 8);
        check("t1_count", int'(bus.car_count), 1);

        // 2: short glitches
        do_reset();
        for (int i = 0; i < 3; i++) begin
            hold(1, LIGHT_RED, 3);
            hold(0, LIGHT_RED, 3);
        end
        hold(0, LIGHT_RED, 4);
        check("t2_count", int'(bus.car_count), 0);

        // 3: three cars drain on sustained green
        do_reset();
        add_cars(3);
        hold(0, LIGHT_GREEN, 20);
        check("t3_count", int'(bus.car_count), 0);

        // 4: interrupted green loses progress
        do_reset();
        add_cars(2);
        hold(0, LIGHT_GREEN, 3);
        hold(0, LIGHT_YELLOW, 1);
        hold(0, LIGHT_GREEN, 4);
        check("t4_no_depart_yet", int'(bus.car_count), 2);
        hold(0, LIGHT_GREEN, 1);
        check("t4_first_depart", int'(bus.car_count), 1);
        hold(0, LIGHT_RED, 2);

        // 5: saturation
        do_reset();
        add_cars(16);
        check("t5_count", int'(bus.car_count), 15);
        check("t5_overflow", int'(bus.overflow), 1);
        hold(0, LIGHT_RED, 5);

        // 6a: arrival and departure on the same edge
        do_reset();
        add_cars(1);
        hold(1, LIGHT_RED, 1);
        hold(1, LIGHT_GREEN, 5);
        check("t6_same_edge_count", int'(bus.car_count), 1);
        check("t6_same_edge_pulse", int'(bus.car_departed), 1);
        hold(1, LIGHT_RED, 2);
        hold(0, LIGHT_RED, 7);

        // 6b: illegal light code
        hold(0, 3'b110, 6);
        check("t6_light_err", int'(bus.light_err), 1);
        check("t6_no_depart", int'(bus.car_count), 1);

        // 6c: reset in mid-debounce
        hold(1, LIGHT_RED, 4);
        tick(0, 1, LIGHT_RED);
        check("t6_reset_count", int'(bus.car_count), 0);
        hold(1, LIGHT_RED, 3);
        hold(0, LIGHT_RED, 6);

        // Randomized traffic
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            r = $urandom_range(0, 39);
            if (r < 16) light = LIGHT_GREEN;
            else if (r < 24) light = LIGHT_YELLOW;
            else if (r < 38) light = LIGHT_RED;
            else light = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) tick(0, raw, light);
            hold(raw, light, len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lr_car_queue_sensor.md
Name: lr_car_queue_sensor

Overview:
Local-road vehicle detector and queue model. It drives lr_has_car into the traffic light controller and consumes that controller's lr_light output.
- Debounces a raw loop-detector input and counts arriving cars.
- Retires one car every DEPART_CYCLES cycles while the local-road light is green.
- Asserts lr_has_car while the queue is non-empty.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized-high (or low) cycles needed to accept a level change; legal range 1..15
DEPART_CYCLES, 5, green cycles needed per car departure; legal range 1..15
MAX_CARS, 15, queue saturation value; must fit in CNT_W bits
CNT_W, 4, width of car_count

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
car_arrive_raw  input  1  asynchronous raw loop detector, high while a car is over the loop
lr_light  input  3  local-road light: 100 green, 010 yellow, 001 red
lr_has_car  output  1  queue non-empty (car_count != 0)
car_count  output  CNT_W  cars currently waiting
car_departed  output  1  one-cycle pulse, high in the cycle after a departure edge
overflow  output  1  sticky flag: an arrival was dropped at MAX_CARS
light_err  output  1  sticky flag: lr_light was not one of the three legal codes

Behaviour:
Reset (rst_n low at a clk edge):
- All registers clear: sync FFs, debounce FSM = LOW, debounce counter, depart timer, car_count.
- Outputs after reset: lr_has_car=0, car_count=0, car_departed=0, overflow=0, light_err=0.
- Reset in mid-debounce or mid-departure discards the pending event.

Synchronizer:
- Two-FF synchronizer on car_arrive_raw produces sync_in.

Debounce FSM (states LOW, RISE_CHK, HIGH, FALL_CHK):
- LOW: sync_in=1 -> RISE_CHK with cnt=1.
- RISE_CHK: sync_in=0 -> LOW.
- RISE_CHK: cnt reaches DEBOUNCE_CYCLES -> HIGH and generate the arrive event on that edge.
- RISE_CHK: otherwise cnt++.
- HIGH/FALL_CHK: symmetric, with no event on the transition back to LOW.
- Resulting latency: with raw held high, car_count increments on the (DEBOUNCE_CYCLES+2)th edge after raw rises. A glitch shorter than DEBOUNCE_CYCLES produces no count.

Departure logic:
- green = (lr_light==3'b100).
- If green and car_count>0 and light legal: depart_timer++ each cycle.
- When depart_timer==DEPART_CYCLES-1, depart on that edge instead: timer clears, count decrements, car_departed=1 for the next cycle.
- Timer clears whenever the light is not green (yellow or red) or car_count==0; partial progress is lost.
- Green held continuously with 3 cars queued yields departures every DEPART_CYCLES edges.

Count update:
- Arrive and depart on the same edge: count unchanged.
- Arrive with count==MAX_CARS and no depart: count holds and overflow is set (sticky until reset).
- Depart only occurs when count>0, so no underflow.

Light check:
- Any lr_light value other than 100/010/001 sets light_err (sticky) and inhibits departure in that cycle.
- The timer clears in that cycle.

Outputs:
- lr_has_car is a decode of the registered car_count; no combinational path from inputs.

Decomposition:
- Shared package (traffic_pkg): light codes LIGHT_GREEN=3'b100, LIGHT_YELLOW=3'b010, LIGHT_RED=3'b001, and the debounce state encoding.
- The traffic light controller imports the same light constants.
- One natural sub-module: sync_debounce (2-FF synchronizer plus debounce FSM, parameter DEBOUNCE_CYCLES, outputs the one-cycle rise event).
- Queue/departure logic stays in the top level.

Test Plan:
1. Reset, then raw high held 10 cycles, lr_light=001 -> car_count 0->1 on edge 6 after the rise; lr_has_car=1; no further increments while raw stays high.
2. Raw pulses of 3 cycles (below DEBOUNCE_CYCLES=4), lr_light=001 -> car_count stays 0; lr_has_car=0.
3. Three debounced arrivals, then lr_light=100 continuously -> departures at edges 5, 10, 15 after green starts; car_departed is a single-cycle pulse each time; count 3->2->1->0; lr_has_car falls with the last departure.
4. Two cars queued, green for 3 cycles, yellow, then green again -> no departure during the first green; timer restarts; first departure 5 edges into the second green.
5. 16 arrivals with light red -> count saturates at 15; overflow=1 and stays 1.
6. Arrival debounce completes on the same edge as a green departure -> count unchanged, car_departed pulses. Separately, lr_light=3'b110 -> light_err=1 and no departure that cycle. Separately, rst_n low mid-debounce -> all outputs 0 on the next edge.
